multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 84 ++++++++
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl_opcode_decode.sv | 15 +
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes and select encodings for the multicycle control FSM.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

    localparam logic [15:0] TRAP_VECTOR = 16'h0004;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] IORD_PC  = 2'b00;
    localparam logic [1:0] IORD_ALU = 2'b01;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_TRAP   = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP,
`endif
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_J,
        CLS_HALT,
        CLS_ILL
    } cls_t;

    typedef struct packed {
        logic       pc_w;
        logic [1:0] iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_w;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle; master is the controller side.
interface multicycle_ctrl_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCw;
    logic [1:0] IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRw;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       retire;
    logic       halted;

    modport master (
        input  opcode, zero, mem_ready,
        output PCw, IorD, MemRead, MemWrite, IRw, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, retire, halted
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCw, IorD, MemRead, MemWrite, IRw, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, retire, halted
    );
endinterface

// File: rtl/multicycle_ctrl_opcode_decode.sv
// ctrl_opcode_decode: maps IR[15:12] to an instruction class for the DECODE transition.
module ctrl_opcode_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output cls_t       cls
);
    assign cls = (opcode <= OP_OR)                       ? CLS_R    :
                 (opcode == OP_ADDI)                     ? CLS_I    :
                 (opcode == OP_LW)                       ? CLS_LD   :
                 (opcode == OP_SW)                       ? CLS_ST   :
                 (opcode == OP_BEQ || opcode == OP_BNE)  ? CLS_BR   :
                 (opcode == OP_JMP)                      ? CLS_J    :
                 (opcode == OP_HALT)                     ? CLS_HALT : CLS_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit multicycle datapath.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes A-E vector to TRAP_VECTOR instead of acting as NOP.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input logic CLK,
    input logic reset,
    multicycle_ctrl_if.master bus
);
    state_t state, state_next;
    cls_t   cls;
    ctrl_t  c;
    logic   halt_seen;

    ctrl_opcode_decode u_dec (
        .opcode (bus.opcode),
        .cls    (cls)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_FETCH;
            halt_seen <= 1'b0;
        end else begin
            state     <= state_next;
            halt_seen <= (state == S_HALT);
        end
    end

    always_comb begin
        c          = '0;
        state_next = state;
        case (state)
            S_FETCH: begin
                c.iord      = IORD_PC;
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_TWO;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCS_ALU;
                // PC/IR only latch in the completing cycle, so a stall never double-increments
                c.pc_w      = bus.mem_ready;
                c.ir_w      = bus.mem_ready;
                state_next  = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALU_ADD;
                case (cls)
                    CLS_R:    state_next = S_R_EXEC;
                    CLS_I:    state_next = S_I_EXEC;
                    CLS_LD,
                    CLS_ST:   state_next = S_MEM_ADDR;
                    CLS_BR:   state_next = S_BRANCH;
                    CLS_J:    state_next = S_JUMP;
                    CLS_HALT: state_next = S_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_next = S_TRAP;
`else
                        state_next = S_FETCH;
                        c.retire   = 1'b1;
`endif
                    end
                endcase
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = bus.opcode[2:0];
                state_next  = S_R_WB;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.retire    = 1'b1;
                state_next  = S_FETCH;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                state_next  = S_I_WB;
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                state_next  = (cls == CLS_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                c.iord     = IORD_ALU;
                c.mem_read = 1'b1;
                state_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEM_WR: begin
                c.iord      = IORD_ALU;
                c.mem_write = 1'b1;
                c.retire    = bus.mem_ready;
                state_next  = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_SUB;
                c.pc_source = PCS_ALUOUT;
                c.pc_w      = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                c.retire    = 1'b1;
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                c.pc_source = PCS_JUMP;
                c.pc_w      = 1'b1;
                c.retire    = 1'b1;
                state_next  = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                c.pc_source = PCS_TRAP;
                c.pc_w      = 1'b1;
                c.retire    = 1'b1;
                state_next  = S_FETCH;
            end
`endif
            S_HALT: begin
                c.halted   = 1'b1;
                c.retire   = ~halt_seen;
            end
            default: state_next = S_FETCH;
        endcase
        // reset aborts whatever is in flight: every enable and select drops to zero
        if (reset)
            c = '0;
    end

    assign bus.PCw      = c.pc_w;
    assign bus.IorD     = c.iord;
    assign bus.MemRead  = c.mem_read;
    assign bus.MemWrite = c.mem_write;
    assign bus.IRw      = c.ir_w;
    assign bus.RegWrite = c.reg_write;
    assign bus.RegDst   = c.reg_dst;
    assign bus.MemtoReg = c.mem_to_reg;
    assign bus.ALUSrcA  = c.alu_src_a;
    assign bus.ALUSrcB  = c.alu_src_b;
    assign bus.ALUOp    = c.alu_op;
    assign bus.PCSource = c.pc_source;
    assign bus.retire   = c.retire;
    assign bus.halted   = c.halted;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors; expected control words queued by stimulus, checked at negedge.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcw;
        logic [1:0] iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       ret;
        logic       hlt;
    } exp_t;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t  eq[$];
    string nq[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t e_fetch(input logic mr);
        exp_t e = '0;
        e.mrd = 1'b1; e.asb = 2'b01; e.pcw = mr; e.irw = mr;
        return e;
    endfunction

    function automatic exp_t e_dec(input logic ret);
        exp_t e = '0;
        e.asb = 2'b11; e.ret = ret;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [1:0] asb, input logic [2:0] aop);
        exp_t e = '0;
        e.asa = 1'b1; e.asb = asb; e.aop = aop;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic rdst, input logic m2r);
        exp_t e = '0;
        e.rw = 1'b1; e.rdst = rdst; e.m2r = m2r; e.ret = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic wr, input logic mr);
        exp_t e = '0;
        e.iord = 2'b01; e.mrd = ~wr; e.mwr = wr; e.ret = wr & mr;
        return e;
    endfunction

    function automatic exp_t e_pc(input logic [1:0] pcs, input logic pcw, input logic br);
        exp_t e = '0;
        e.pcs = pcs; e.pcw = pcw; e.ret = 1'b1;
        if (br) begin e.asa = 1'b1; e.aop = 3'b001; end
        return e;
    endfunction

    function automatic exp_t e_halt(input logic ret);
        exp_t e = '0;
        e.hlt = 1'b1; e.ret = ret;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic [3:0] op, input logic z, input logic mr,
                       input exp_t e, input string nm);
        reset         = r;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        eq.push_back(e);
        nq.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op);
        cyc(0, op, 0, 1, e_fetch(1), "fetch");
    endtask

    always @(negedge CLK) begin
        if (eq.size() > 0) begin
            exp_t  e, g;
            string nm;
            e  = eq.pop_front();
            nm = nq.pop_front();
            g  = {bus.PCw, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRw, bus.RegWrite,
                  bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.retire, bus.halted};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %b required %b", nm, g, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = 4'hF; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge CLK);
        #1;
        cyc(1, 4'hF, 1, 1, '0, "reset0");
        cyc(1, 4'h5, 0, 1, '0, "reset1");

        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 0, e_fetch(0), "fetch_stall");
        cyc(0, 4'h0, 0, 1, e_fetch(1), "fetch_go");
        cyc(0, 4'h0, 1, 1, e_dec(0), "add_dec");
        cyc(0, 4'h0, 1, 1, e_exec(2'b00, 3'b000), "add_exec");
        cyc(0, 4'h0, 1, 1, e_wb(1, 0), "add_wb");

        for (int op = 1; op < 4; op++) begin
            fetch(4'(op));
            cyc(0, 4'(op), 0, 0, e_dec(0), "r_dec");
            cyc(0, 4'(op), 0, 0, e_exec(2'b00, 3'(op)), "r_exec");
            cyc(0, 4'(op), 0, 0, e_wb(1, 0), "r_wb");
        end

        fetch(4'h4);
        cyc(0, 4'h4, 0, 1, e_dec(0), "addi_dec");
        cyc(0, 4'h4, 0, 1, e_exec(2'b10, 3'b000), "addi_exec");
        cyc(0, 4'h4, 0, 1, e_wb(0, 0), "addi_wb");

        fetch(4'h5);
        cyc(0, 4'h5, 0, 1, e_dec(0), "lw_dec");
        cyc(0, 4'h5, 0, 1, e_exec(2'b10, 3'b000), "lw_addr");
        cyc(0, 4'h5, 0, 0, e_mem(0, 0), "lw_rd_wait1");
        cyc(0, 4'h5, 0, 0, e_mem(0, 0), "lw_rd_wait2");
        cyc(0, 4'h5, 0, 1, e_mem(0, 1), "lw_rd_done");
        cyc(0, 4'h5, 0, 0, e_wb(0, 1), "lw_wb");

        fetch(4'h6);
        cyc(0, 4'h6, 0, 1, e_dec(0), "sw_dec");
        cyc(0, 4'h6, 0, 1, e_exec(2'b10, 3'b000), "sw_addr");
        cyc(0, 4'h6, 0, 0, e_mem(1, 0), "sw_wr_wait");
        cyc(0, 4'h6, 0, 1, e_mem(1, 1), "sw_wr_done");

        fetch(4'h7);
        cyc(0, 4'h7, 1, 1, e_dec(0), "beq_dec");
        cyc(0, 4'h7, 1, 1, e_pc(2'b01, 1, 1), "beq_taken");
        fetch(4'h7);
        cyc(0, 4'h7, 0, 1, e_dec(0), "beq_dec");
        cyc(0, 4'h7, 0, 1, e_pc(2'b01, 0, 1), "beq_not_taken");
        fetch(4'h8);
        cyc(0, 4'h8, 1, 1, e_dec(0), "bne_dec");
        cyc(0, 4'h8, 1, 1, e_pc(2'b01, 0, 1), "bne_not_taken");
        fetch(4'h8);
        cyc(0, 4'h8, 0, 1, e_dec(0), "bne_dec");
        cyc(0, 4'h8, 0, 1, e_pc(2'b01, 1, 1), "bne_taken");

        fetch(4'h9);
        cyc(0, 4'h9, 0, 1, e_dec(0), "jmp_dec");
        cyc(0, 4'h9, 0, 1, e_pc(2'b10, 1, 0), "jmp");

        fetch(4'hB);
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc(0, 4'hB, 0, 1, e_dec(0), "ill_dec");
        cyc(0, 4'hB, 0, 1, e_pc(2'b11, 1, 0), "ill_trap");
`else
        cyc(0, 4'hB, 0, 1, e_dec(1), "ill_dec_nop");
`endif
        cyc(0, 4'hB, 0, 0, e_fetch(0), "ill_back_to_fetch");
        cyc(0, 4'h5, 0, 1, e_fetch(1), "fetch_lw");
        cyc(0, 4'h5, 0, 1, e_dec(0), "lw2_dec");
        cyc(0, 4'h5, 0, 1, e_exec(2'b10, 3'b000), "lw2_addr");
        cyc(0, 4'h5, 0, 0, e_mem(0, 0), "lw2_stall");
        cyc(1, 4'h5, 1, 1, '0, "reset_abort");
        cyc(0, 4'hF, 0, 1, e_fetch(1), "fetch_after_abort");

        cyc(0, 4'hF, 0, 1, e_dec(0), "halt_dec");
        cyc(0, 4'hF, 0, 1, e_halt(1), "halt_entry");
        for (int i = 0; i < 20; i++) cyc(0, 4'(i), 1'(i), 1'(i >> 1), e_halt(0), "halt_hold");
        cyc(1, 4'hF, 0, 1, '0, "halt_reset");
        cyc(0, 4'h0, 0, 1, e_fetch(1), "fetch_after_halt");

        @(negedge CLK);
        #1;
        checks++;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", eq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
